// File: rtl/bcd_timer_pkg.sv
// Shared types and BCD helpers for the multi-field up/down timer.
// BCD_TIMER_PRESCALER_EN (top only) selects the internal tick prescaler.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } state_e;

  localparam int FIELD_W = 8;
  localparam logic [FIELD_W-1:0] SEC_MAX = 8'h59;

  function automatic logic [FIELD_W-1:0] bcd_inc(input logic [FIELD_W-1:0] v,
                                                 input logic [FIELD_W-1:0] max);
    logic [FIELD_W-1:0] r;
    if (v == max)              r = '0;
    else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
    else                       r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [FIELD_W-1:0] bcd_dec(input logic [FIELD_W-1:0] v,
                                                 input logic [FIELD_W-1:0] max);
    logic [FIELD_W-1:0] r;
    if (v == '0)               r = max;
    else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
    else                       r = {v[7:4], v[3:0] - 4'd1};
    return r;
  endfunction

  // Lower fields saturate each digit independently; the top field saturates as a whole.
  function automatic logic [FIELD_W-1:0] bcd_clamp(input logic [FIELD_W-1:0] v,
                                                   input logic [FIELD_W-1:0] max,
                                                   input logic              is_top);
    logic [3:0]         t;
    logic [3:0]         u;
    logic [FIELD_W-1:0] r;
    u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    if (is_top) begin
      t = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
      r = {t, u};
      if (r > max) r = max;
    end else begin
      t = (v[7:4] > max[7:4]) ? max[7:4] : v[7:4];
      r = {t, u};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_timer_chain_field.sv
// One two-digit BCD field: clear > load > step; value and carry update one cycle after step_i.
// wrap_o is combinational so the step ripples through the chain within the same cycle.
module bcd_field_counter
  import bcd_timer_pkg::*;
#(
  parameter logic [FIELD_W-1:0] MAX    = SEC_MAX,
  parameter logic               IS_TOP = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [FIELD_W-1:0] load_val_i,
  input  logic               step_i,
  input  logic               up_i,
  output logic [FIELD_W-1:0] value_o,
  output logic               carry_o,
  output logic               wrap_o,
  output logic               at_max_o,
  output logic               at_zero_o
);

  logic [FIELD_W-1:0] value_q, value_d;
  logic               carry_q, carry_d;

  assign at_max_o  = (value_q == MAX);
  assign at_zero_o = (value_q == '0);
  assign wrap_o    = step_i & (up_i ? at_max_o : at_zero_o);

  always_comb begin
    value_d = value_q;
    carry_d = 1'b0;
    if (clr_i) begin
      value_d = '0;
    end else if (load_i) begin
      value_d = bcd_clamp(load_val_i, MAX, IS_TOP);
    end else if (step_i) begin
      value_d = up_i ? bcd_inc(value_q, MAX) : bcd_dec(value_q, MAX);
      carry_d = wrap_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      value_q <= '0;
      carry_q <= 1'b0;
    end else begin
      value_q <= value_d;
      carry_q <= carry_d;
    end
  end

  assign value_o = value_q;
  assign carry_o = carry_q;

endmodule

// File: rtl/bcd_timer_chain.sv
// Multi-field BCD up/down timer with run/pause/done FSM; count/carry/done update 1 cycle after tick.
// No backpressure: ticks outside RUN are dropped. BCD_TIMER_PRESCALER_EN builds an internal tick.
module bcd_timer_chain
  import bcd_timer_pkg::*;
#(
  parameter int                 FIELDS   = 2,
  parameter logic [FIELD_W-1:0] TOP_MAX  = 8'h59,
  parameter int                 PRESCALE = 50000000
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic                  tick_en,
  input  logic                  set_time,
  input  logic                  UpOrDown,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic [8*FIELDS-1:0]   init_value,
  output logic [8*FIELDS-1:0]   count,
  output logic [FIELDS-1:0]     carry,
  output logic                  running,
  output logic                  done
);

  state_e            state_q, state_d;
  logic              done_q, done_d;
  logic              tick;
  logic              count_en;
  logic              terminal;
  logic [FIELDS:0]   step;
  logic [FIELDS-1:0] at_max;
  logic [FIELDS-1:0] at_zero;

`ifdef BCD_TIMER_PRESCALER_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0] ps_q, ps_d;
  logic            unused_tick_en;

  assign unused_tick_en = tick_en;

  always_comb begin
    ps_d = ps_q;
    tick = 1'b0;
    if (stop || set_time || state_q != ST_RUN) begin
      ps_d = '0;
    end else if (ps_q == PS_W'(PRESCALE - 1)) begin
      ps_d = '0;
      tick = 1'b1;
    end else begin
      ps_d = ps_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) ps_q <= '0;
    else        ps_q <= ps_d;
  end
`else
  logic unused_prescale;
  assign unused_prescale = (PRESCALE != 0);
  assign tick            = tick_en;
`endif

  assign terminal = UpOrDown ? (&at_max) : (&at_zero);
  // Any accepted control wins over a same-cycle tick.
  assign count_en = tick && (state_q == ST_RUN) && !stop && !set_time && !pause;
  assign step[0]  = count_en && !terminal;

  always_comb begin
    state_d = state_q;
    if (stop || set_time) begin
      state_d = ST_IDLE;
    end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSED)) begin
      state_d = ST_RUN;
    end else if (pause && state_q == ST_RUN) begin
      state_d = ST_PAUSED;
    end else if (count_en && terminal) begin
      state_d = ST_DONE;
    end
    done_d = (state_d == ST_DONE) && (state_q != ST_DONE);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  for (genvar i = 0; i < FIELDS; i++) begin : g_field
    localparam logic               IS_TOP = (i == FIELDS - 1);
    localparam logic [FIELD_W-1:0] FMAX   = IS_TOP ? TOP_MAX : SEC_MAX;

    bcd_field_counter #(
      .MAX    (FMAX),
      .IS_TOP (IS_TOP)
    ) u_field (
      .clk_i      (Clk),
      .rst_n_i    (reset),
      .clr_i      (stop),
      .load_i     (set_time),
      .load_val_i (init_value[i*FIELD_W +: FIELD_W]),
      .step_i     (step[i]),
      .up_i       (UpOrDown),
      .value_o    (count[i*FIELD_W +: FIELD_W]),
      .carry_o    (carry[i]),
      .wrap_o     (step[i+1]),
      .at_max_o   (at_max[i]),
      .at_zero_o  (at_zero[i])
    );
  end

  logic unused_top_wrap;
  assign unused_top_wrap = step[FIELDS];

  assign running = (state_q == ST_RUN);
  assign done    = done_q;

endmodule

// File: tb/tb_bcd_timer_chain.sv
// Directed scoreboard bench for bcd_timer_chain (FIELDS=2, TOP_MAX=59, default build).
module tb_bcd_timer_chain;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick_en = 1'b0;
  logic        set_time = 1'b0;
  logic        UpOrDown = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] init_value = '0;
  logic [15:0] count;
  logic [1:0]  carry;
  logic        running;
  logic        done;

  bcd_timer_chain dut (
    .Clk        (Clk),
    .reset      (reset),
    .tick_en    (tick_en),
    .set_time   (set_time),
    .UpOrDown   (UpOrDown),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .init_value (init_value),
    .count      (count),
    .carry      (carry),
    .running    (running),
    .done       (done)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       nm;
    logic [15:0] cnt;
    logic [1:0]  cry;
    logic        run;
    logic        dn;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: outputs are registered, so the falling edge is a stable sampling point.
  always @(negedge Clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      n_cmp = n_cmp + 1;
      if (mon_e.cyc != cyc || count !== mon_e.cnt || carry !== mon_e.cry ||
          running !== mon_e.run || done !== mon_e.dn) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got count=%h carry=%b running=%b done=%b @cyc %0d, want count=%h carry=%b running=%b done=%b @cyc %0d",
                 mon_e.nm, count, carry, running, done, cyc,
                 mon_e.cnt, mon_e.cry, mon_e.run, mon_e.dn, mon_e.cyc);
      end
    end
  end

  // Expect the given outputs after the coming clock edge, then drop one-cycle pulses.
  task automatic chk(input string nm, input logic [15:0] c, input logic [1:0] cr,
                     input logic r, input logic d);
    exp_q.push_back('{cyc + 1, nm, c, cr, r, d});
    @(negedge Clk);
    stop = 1'b0; set_time = 1'b0; start = 1'b0; pause = 1'b0; tick_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge Clk);
    tick_en = 1'b1; start = 1'b1; set_time = 1'b1; init_value = 16'h1234;
    chk("reset_state", 16'h0000, 2'b00, 1'b0, 1'b0);
    reset = 1'b1;

    // 1: up count with units and field carry
    UpOrDown = 1'b1; set_time = 1'b1; init_value = 16'h0158;
    chk("t1_load", 16'h0158, 2'b00, 1'b0, 1'b0);
    start = 1'b1;             chk("t1_start", 16'h0158, 2'b00, 1'b1, 1'b0);
    tick_en = 1'b1;           chk("t1_tick1", 16'h0159, 2'b00, 1'b1, 1'b0);
    tick_en = 1'b1;           chk("t1_tick2", 16'h0200, 2'b01, 1'b1, 1'b0);
    tick_en = 1'b1;           chk("t1_tick3", 16'h0201, 2'b00, 1'b1, 1'b0);

    // 2: down count into terminal zero
    UpOrDown = 1'b0; set_time = 1'b1; init_value = 16'h0002;
    chk("t2_load", 16'h0002, 2'b00, 1'b0, 1'b0);
    start = 1'b1;             chk("t2_start", 16'h0002, 2'b00, 1'b1, 1'b0);
    tick_en = 1'b1;           chk("t2_tick1", 16'h0001, 2'b00, 1'b1, 1'b0);
    tick_en = 1'b1;           chk("t2_tick2", 16'h0000, 2'b00, 1'b1, 1'b0);
    tick_en = 1'b1;           chk("t2_tick3_done", 16'h0000, 2'b00, 1'b0, 1'b1);
    tick_en = 1'b1;           chk("t2_done_frozen", 16'h0000, 2'b00, 1'b0, 1'b0);
    start = 1'b1;             chk("t2_start_in_done", 16'h0000, 2'b00, 1'b0, 1'b0);

    // Down borrow across fields
    set_time = 1'b1; init_value = 16'h0100;
    chk("bw_load", 16'h0100, 2'b00, 1'b0, 1'b0);
    start = 1'b1;             chk("bw_start", 16'h0100, 2'b00, 1'b1, 1'b0);
    tick_en = 1'b1;           chk("bw_tick", 16'h0059, 2'b01, 1'b1, 1'b0);

    // 3: up into terminal all-max
    UpOrDown = 1'b1; set_time = 1'b1; init_value = 16'h5958;
    chk("t3_load", 16'h5958, 2'b00, 1'b0, 1'b0);
    start = 1'b1;             chk("t3_start", 16'h5958, 2'b00, 1'b1, 1'b0);
    tick_en = 1'b1;           chk("t3_tick1", 16'h5959, 2'b00, 1'b1, 1'b0);
    tick_en = 1'b1;           chk("t3_tick2_done", 16'h5959, 2'b00, 1'b0, 1'b1);
    tick_en = 1'b1;           chk("t3_after", 16'h5959, 2'b00, 1'b0, 1'b0);

    // 4: pause freezes count, resume continues
    set_time = 1'b1; init_value = 16'h0010;
    chk("t4_load", 16'h0010, 2'b00, 1'b0, 1'b0);
    start = 1'b1;             chk("t4_start", 16'h0010, 2'b00, 1'b1, 1'b0);
    pause = 1'b1;             chk("t4_pause", 16'h0010, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick_en = 1'b1;         chk("t4_paused_tick", 16'h0010, 2'b00, 1'b0, 1'b0);
    end
    start = 1'b1;             chk("t4_resume", 16'h0010, 2'b00, 1'b1, 1'b0);
    tick_en = 1'b1;           chk("t4_tick", 16'h0011, 2'b00, 1'b1, 1'b0);

    // 5: stop beats start in PAUSED
    pause = 1'b1;             chk("t5_pause", 16'h0011, 2'b00, 1'b0, 1'b0);
    stop = 1'b1; start = 1'b1;
    chk("t5_stop_start", 16'h0000, 2'b00, 1'b0, 1'b0);
    tick_en = 1'b1;           chk("t5_idle_tick", 16'h0000, 2'b00, 1'b0, 1'b0);

    // 6: clamp on load, then asynchronous reset while running with a tick pending
    set_time = 1'b1; init_value = 16'h7A3F;
    chk("t6_clamp", 16'h5939, 2'b00, 1'b0, 1'b0);
    start = 1'b1;             chk("t6_start", 16'h5939, 2'b00, 1'b1, 1'b0);
    tick_en = 1'b1;
    @(posedge Clk);
    #1 reset = 1'b0;
    #1;
    n_cmp = n_cmp + 1;
    if (count !== 16'h0000 || carry !== 2'b00 || running !== 1'b0 || done !== 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL t6_async_immediate: got count=%h carry=%b running=%b done=%b before next edge",
               count, carry, running, done);
    end
    exp_q.push_back('{cyc, "t6_async_reset", 16'h0000, 2'b00, 1'b0, 1'b0});
    @(negedge Clk);
    tick_en = 1'b0;
    reset = 1'b1;
    tick_en = 1'b1; start = 1'b0;
    chk("t6_after_reset", 16'h0000, 2'b00, 1'b0, 1'b0);

    tick_en = 1'b1;
    @(negedge Clk);
    tick_en = 1'b0;
    n_cmp = n_cmp + 1;
    if (count !== 16'h0000 || running !== 1'b0) begin
      n_bad = n_bad + 1;
      $display("FAIL t6_idle_after_reset: got count=%h running=%b, want 0000/0", count, running);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
    while (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s: never compared, expected at cyc %0d", mon_e.nm, mon_e.cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
